uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: accepts a parallel data word through a valid/busy handshake and serializes it as one frame on `tx_out` (start bit, data LSB-first, optional parity bit, one stop bit). Each bit is held for `prescale` clock cycles, matching the receiver's per-bit oversampling count. It sits in the UART block beside the receive path, fed by the system's transmit FIFO or controller.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_WIDTH`, 6: width of `prescale`.
- `CLK`  in  1: clock, all state on rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `p_data`  in  DATA_WIDTH: word to transmit.
- `data_valid`  in  1: `p_data` is valid for acceptance.
- `par_en`  in  1: 1 = parity bit included in the frame.
- `par_typ`  in  1: 0 = even parity, 1 = odd parity.
- `prescale`  in  PRESCALE_WIDTH: CLK cycles per bit; 0 is treated as 1.
- `tx_out`  out  1: serial line, idle high.
- `busy`  out  1: frame in progress; word not accepted.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance occurs on the rising edge where state = IDLE and `data_valid` = 1. `p_data`, `par_en`, `par_typ` and `prescale` are latched on that edge. Changes to these inputs afterward have no effect on the current frame.
- `data_valid` is ignored outside IDLE. A held `data_valid` produces a new frame after each IDLE cycle.
- Transitions:
  - IDLE → START on acceptance.
  - START → DATA after one bit period.
  - DATA → PARITY after DATA_WIDTH bit periods if the latched `par_en` = 1; otherwise DATA → STOP.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after one bit period.
- `tx_out` by state:
  - IDLE = 1; START = 0; STOP = 1.
  - DATA: shift register bit 0, shifted right once per completed bit period, so data goes out LSB first.
  - PARITY: XOR-reduction of the latched word when `par_typ` = 0, XNOR-reduction when `par_typ` = 1.
- Bit-period counter counts 0 to (latched prescale − 1) and wraps to 0 at every bit boundary. Data bit index counts 0 to DATA_WIDTH−1, with width $clog2(DATA_WIDTH).
- Parity is computed from the latched word, not the live `p_data`.

## Timing
- Reset values: `tx_out` = 1, `busy` = 0, state = IDLE, all counters and the shift register = 0.
- Reset mid-frame: the frame is aborted immediately (asynchronously). The line returns high and no partial data is resumed.
- `tx_out` and `busy` are registered, with no combinational path from inputs to outputs.
- Latency: the start bit appears on `tx_out`, and `busy` rises, in the first cycle after the acceptance edge.
- Frame length: (2 + DATA_WIDTH + P) × prescale cycles, where P = 1 if parity is enabled, else 0. `busy` is high for exactly this many cycles.
- After STOP, the block spends at least one cycle in IDLE with `busy` = 0 and `tx_out` = 1. The minimum inter-frame gap is one CLK cycle.
- Changing `prescale` mid-frame has no effect; the new value applies from the next acceptance.

## Configuration
- `UART_TX_PARITY_EN`: when defined, the PARITY state and parity logic are compiled in and behave as described above.
- When undefined, PARITY is removed and DATA → STOP always. The `par_en` and `par_typ` ports remain in the interface but are ignored, and the frame is always (2 + DATA_WIDTH) × prescale cycles.

## Structure
- Package `uart_tx_pkg` holds:
  - the FSM state enum;
  - parity-type constants `PAR_EVEN` = 0 and `PAR_ODD` = 1;
  - line-level constants `LINE_IDLE` = 1 and `LINE_START` = 0.
- Sub-module `uart_tx_serializer` contains the shift register, data bit counter and a `ser_done` flag. It is loaded on acceptance and advanced by a bit-tick strobe from the top-level prescale counter.
- The FSM, prescale counter, parity calculation and output mux live in the `uart_tx` top.

## Test plan
- Parity on, even: DATA_WIDTH = 8, prescale = 1, `p_data` = 8'hA5, `par_en` = 1, `par_typ` = 0. Required `tx_out` sequence: 0, 1,0,1,0,0,1,0,1, 0, 1. `busy` is high for exactly 11 cycles.
- Parity on, odd: `p_data` = 8'h07, `par_typ` = 1, prescale = 4. Required: parity bit = 0, every bit held exactly 4 cycles, `busy` high for 44 cycles.
- Parity off: `par_en` = 0, `p_data` = 8'hFF, prescale = 2. Required: frame of 10 bits over 20 cycles with no parity bit. Without `UART_TX_PARITY_EN`, `par_en` = 1 must also give 20 cycles.
- Back-to-back: `data_valid` held high with 8'h3C and then 8'hC3 (prescale = 1). Required: two complete frames separated by exactly one idle-high cycle. Changing `p_data` mid-frame must not corrupt the first frame.
- Reset mid-frame: assert `RST` during the DATA state of an 8'h55 frame. Required: `tx_out` = 1 and `busy` = 0 immediately, without waiting for a clock edge. After release, a new 8'h0F frame is transmitted correctly.
- `prescale` = 0: `p_data` = 8'h81. Required: behaviour is identical to prescale = 1, an 11-cycle frame with parity on.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmitter.
//   - tx_state_e : transmitter FSM state encoding (also driven on state_dbg)
//   - PAR_EVEN / PAR_ODD : values of the par_typ input
//   - LINE_IDLE / LINE_START : serial line levels
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and data bit counter of the UART
// transmitter.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   load          load load_data and clear the bit index (frame acceptance)
//   load_data     word to serialize
//   shift_en      one completed data bit period: shift right, advance index
//   ser_bit_next  value bit 0 of the shift register takes on the next edge,
//                 so the parent can register tx_out without a cycle of lag
//   ser_done      bit index is on the last data bit
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    output logic                  ser_bit_next,
    output logic                  ser_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    assign ser_done = (idx_q == LAST_IDX);

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load) begin
            shift_d = load_data;
            idx_d   = '0;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
            idx_d   = ser_done ? '0 : idx_q + 1'b1;
        end
    end

    assign ser_bit_next = shift_d[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Accepts p_data when idle and data_valid is high,
// then sends start bit, DATA_WIDTH data bits LSB first, optional parity bit and
// one stop bit, each held for the latched prescale count (0 behaves as 1).
// Build option: define UART_TX_PARITY_EN to compile in the parity bit; without
// it par_en and par_typ are ignored and frames never carry parity.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   p_data      word to transmit, latched on acceptance
//   data_valid  request; accepted on an edge where the FSM is IDLE
//   par_en      1 = append parity bit (latched on acceptance)
//   par_typ     PAR_EVEN / PAR_ODD (latched on acceptance)
//   prescale    clock cycles per bit (latched on acceptance)
//   tx_out      registered serial line, idle high
//   busy        registered, high for every cycle of a frame
//   state_dbg   current FSM state (tx_state_e encoding)
// Handshake: a word is taken on a rising edge with data_valid = 1 while busy
// is low; busy then stays high for the whole frame and data_valid is ignored.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    tx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_out_q, tx_out_d;
    logic                      busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
`else
    logic                      unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    logic accept;
    logic bit_tick;
    logic shift_en;
    logic ser_bit_next;
    logic ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK          (CLK),
        .RST          (RST),
        .load         (accept),
        .load_data    (p_data),
        .shift_en     (shift_en),
        .ser_bit_next (ser_bit_next),
        .ser_done     (ser_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        accept   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        // Last cycle of the current bit period.
        bit_tick = (state_q != IDLE) && (cnt_q == (presc_q - 1'b1));
        shift_en = bit_tick && (state_q == DATA);

        if (state_q != IDLE) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                    presc_d = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
`ifdef UART_TX_PARITY_EN
                    par_en_d = par_en;
                    // Even: XOR of the word; odd: XNOR. Taken from the word as
                    // latched on this edge, so later p_data changes cannot leak in.
                    par_bit_d = (^p_data) ^ (par_typ == PAR_ODD);
`endif
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick && ser_done) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered line
        // changes on the same edge as the state.
        case (state_d)
            IDLE:    tx_out_d = LINE_IDLE;
            START:   tx_out_d = LINE_START;
            DATA:    tx_out_d = ser_bit_next;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = par_bit_q;
`endif
            STOP:    tx_out_d = LINE_IDLE;
            default: tx_out_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            tx_out_q  <= LINE_IDLE;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign tx_out    = tx_out_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Expected line levels are pushed
// per clock cycle into exp_q when a frame is requested and popped as the
// frame is observed on tx_out.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic [PW-1:0] prescale;
    logic          tx_out;
    logic          busy;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         exp_len;
    } vec_t;

    vec_t vecs[5];

    uart_tx #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input int n);
        repeat (n) exp_q.push_back(b);
    endtask

    // Reference frame model: per-cycle line levels.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps);
        int eps;
        eps = (ps == 0) ? 1 : int'(ps);
        push_bit(1'b0, eps);
        for (int i = 0; i < DW; i++) push_bit(d[i], eps);
        if (pe && PB == 1) push_bit(pt ? ~^d : ^d, eps);
        push_bit(1'b1, eps);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    // Drive one request and scramble the inputs right after acceptance.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps);
        wait_idle();
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        push_frame(d, pe, pt, ps);
        @(posedge CLK);
        #1;
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
        prescale   = 6'($urandom_range(0, 63));
    endtask

    // Observe one frame starting at the next falling edge.
    task automatic check_frame(input string name, input int exp_len, input bit drop_dv);
        int len;
        len = 0;
        @(negedge CLK);
        while (busy === 1'b1 && len < 4000) begin
            if (exp_q.size() == 0) begin
                check({name, "_overrun"}, len, exp_len);
                break;
            end
            check({name, "_bit"}, {31'b0, tx_out}, {31'b0, exp_q.pop_front()});
            len++;
            if (drop_dv) data_valid = 1'b0;
            @(negedge CLK);
        end
        check({name, "_len"}, len, exp_len);
        check({name, "_idle_tx"}, {31'b0, tx_out}, 32'd1);
        check({name, "_leftover"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        RST        = 1'b1;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = '0;

        vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd1, exp_len: (10 + PB) * 1};
        vecs[1] = '{data: 8'h07, pe: 1'b1, pt: 1'b1, ps: 6'd4, exp_len: (10 + PB) * 4};
        vecs[2] = '{data: 8'hFF, pe: 1'b0, pt: 1'b0, ps: 6'd2, exp_len: 20};
        vecs[3] = '{data: 8'hFF, pe: 1'b1, pt: 1'b0, ps: 6'd2, exp_len: (10 + PB) * 2};
        vecs[4] = '{data: 8'h81, pe: 1'b1, pt: 1'b0, ps: 6'd0, exp_len: (10 + PB) * 1};

        // reset values
        #3;
        check("rst_tx", {31'b0, tx_out}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_state", {29'b0, state_dbg}, 32'(IDLE));
        @(negedge CLK);
        RST = 1'b0;

        // table-driven frames
        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_len, 1'b0);
        end

        // back-to-back with data_valid held, p_data changed mid-frame
        wait_idle();
        p_data     = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        prescale   = 6'd1;
        data_valid = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b0, 6'd1);
        @(posedge CLK);
        #1;
        p_data = 8'hC3;
        check_frame("b2b_first", 10 + PB, 1'b0);
        push_frame(8'hC3, 1'b1, 1'b0, 6'd1);
        check_frame("b2b_second", 10 + PB, 1'b1);

        // asynchronous reset during DATA
        send(8'h55, 1'b1, 1'b0, 6'd2);
        repeat (5) @(negedge CLK);
        check("rst_mid_pre_tx", {31'b0, tx_out}, 32'd0);
        check("rst_mid_pre_state", {29'b0, state_dbg}, 32'(DATA));
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_tx", {31'b0, tx_out}, 32'd1);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_state", {29'b0, state_dbg}, 32'(IDLE));
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        send(8'h0F, 1'b1, 1'b1, 6'd1);
        check_frame("after_rst", 10 + PB, 1'b0);

        // random frames
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            logic [5:0] ps;
            int         eps;
            d   = 8'($urandom_range(0, 255));
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            ps  = 6'($urandom_range(0, 3));
            eps = (ps == 0) ? 1 : int'(ps);
            send(d, pe, pt, ps);
            check_frame($sformatf("rand%0d", k), (10 + ((PB == 1 && pe) ? 1 : 0)) * eps, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
